sequence_checker: RTL

Issues the encoded four-digit sequence to the seven-segment sequence display and grades the player's entry. It is the issuing and grading end of the sequence stage. On entry to the sequence game stage it draws a pseudo-random code and drives it as a 16-bit one-cold nibble word. It then holds through the display window and captures one submitted digit per `button_next` press, comparing each against the issued code. It reports pass or fail to the game controller.

---
 rtl/seq_pkg.sv | 52 +++++
 rtl/seq_lfsr.sv | 25 ++
 rtl/sequence_checker.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence stage: FSM states, one-cold digits, LFSR setup.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    SHOW    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One-cold digit encodings as shown on the seven-segment select lines
  localparam logic [3:0] DIG0 = 4'b1110;
  localparam logic [3:0] DIG1 = 4'b1101;
  localparam logic [3:0] DIG2 = 4'b1011;
  localparam logic [3:0] DIG3 = 4'b0111;

  // Fibonacci LFSR: taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] STAGE_CODE_DEF = 8'h10;

  // Map one random bit pair onto a one-cold digit
  function automatic logic [3:0] pair_to_digit(input logic [1:0] pair);
    case (pair)
      2'b00:   return DIG0;
      2'b01:   return DIG1;
      2'b10:   return DIG2;
      default: return DIG3;
    endcase
  endfunction

  // Build the four-digit code; bits [7:6] become the leftmost nibble
  function automatic logic [15:0] build_code(input logic [7:0] draw);
    return {pair_to_digit(draw[7:6]), pair_to_digit(draw[5:4]),
            pair_to_digit(draw[3:2]), pair_to_digit(draw[1:0])};
  endfunction

  // Select the nibble for a digit index (0 = leftmost)
  function automatic logic [3:0] code_nibble(input logic [15:0] code, input logic [1:0] idx);
    case (idx)
      2'd0:    return code[15:12];
      2'd1:    return code[11:8];
      2'd2:    return code[7:4];
      default: return code[3:0];
    endcase
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes the low byte used to draw a code.
// Latency: advances once per clock; reset loads the seed on the next edge.
// Backpressure: none, never stalls.
module seq_lfsr
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] draw
);

  logic [15:0] lfsr;

  // Shift left, feeding back the XOR of the tapped bits into bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign draw = lfsr[7:0];

endmodule

// File: rtl/sequence_checker.sv
// Issues a random one-cold four-digit code, waits out the display window, grades four button entries.
// Latency: code valid one cycle after arming; result registered one cycle after the last capture.
// Backpressure: none; presses outside entry are dropped. Optional macro SEQ_TIMEOUT_EN bounds entry time.
module sequence_checker
  import seq_pkg::*;
#(
  parameter logic [7:0] STAGE_CODE  = STAGE_CODE_DEF,
  parameter int         SHOW_SEC    = 3,
  parameter int         TIMEOUT_SEC = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  game_state,
  input  logic        one_sec,
  input  logic        button_next,
  input  logic [3:0]  resp_digit,
  output logic [15:0] seq_code,
  output logic        seq_valid,
  output logic [1:0]  digit_idx,
  output logic        done,
  output logic        pass,
  output logic        fail
);

`ifdef SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [4:0] SHOW_LIM = SHOW_SEC[4:0];
  localparam logic [4:0] TMO_LIM  = TIMEOUT_SEC[4:0];

  state_t      state, next_state;
  logic [7:0]  draw;
  logic        btn_q;
  logic        err;
  logic [4:0]  sec_cnt;
  logic [4:0]  sec_inc;
  logic        armed, rise, show_hit, tmo_hit, dig_match;

  seq_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .draw  (draw)
  );

  // Decode conditions shared by next-state and datapath; pulse counter saturates
  always_comb begin
    armed     = (game_state == STAGE_CODE);
    rise      = button_next & ~btn_q;
    sec_inc   = (sec_cnt == 5'h1F) ? sec_cnt : sec_cnt + 5'd1;
    show_hit  = one_sec && (sec_inc >= SHOW_LIM);
    tmo_hit   = TMO_EN && (state == COLLECT) && one_sec && (sec_inc >= TMO_LIM);
    dig_match = (resp_digit == code_nibble(seq_code, digit_idx));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: leaving the stage aborts; timeout beats a coincident press
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (armed) next_state = GEN;
      GEN:     next_state = armed ? SHOW : IDLE;
      SHOW: begin
        if (!armed)        next_state = IDLE;
        else if (show_hit) next_state = COLLECT;
      end
      COLLECT: begin
        if (!armed)                           next_state = IDLE;
        else if (tmo_hit)                     next_state = DONE;
        else if (rise && digit_idx == 2'd3)   next_state = DONE;
      end
      DONE:    if (!armed) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, counters, sticky error and button history
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q     <= 1'b0;
      err       <= 1'b0;
      sec_cnt   <= 5'd0;
      seq_code  <= 16'hFFFF;
      seq_valid <= 1'b0;
      digit_idx <= 2'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      btn_q <= button_next;
      done  <= (state == DONE) && (next_state == DONE);
      pass  <= (state == DONE) && (next_state == DONE) && !err;
      fail  <= (state == DONE) && (next_state == DONE) && err;
      case (state)
        IDLE, GEN: begin
          err       <= 1'b0;
          sec_cnt   <= 5'd0;
          digit_idx <= 2'd0;
          if (state == GEN) begin
            seq_code  <= build_code(draw);
            seq_valid <= 1'b1;
          end
        end
        SHOW: begin
          if (one_sec) sec_cnt <= show_hit ? 5'd0 : sec_inc;
        end
        COLLECT: begin
          if (TMO_EN && one_sec) sec_cnt <= sec_inc;
          if (tmo_hit) begin
            err <= 1'b1;
          end else if (rise) begin
            if (!dig_match) err <= 1'b1;
            if (digit_idx != 2'd3) digit_idx <= digit_idx + 2'd1;
          end
        end
        default: ;
      endcase
      // Returning to idle blanks the display
      if (next_state == IDLE) begin
        seq_code  <= 16'hFFFF;
        seq_valid <= 1'b0;
        digit_idx <= 2'd0;
      end
    end
  end

endmodule
